// File: rtl/bcd_pkg.sv
// Shared constants and types for the BCD conversion scheduler.
// The optional macro BCD_CLAMP_EN saturates stored results at 12'h099.
package bcd_pkg;

    localparam int unsigned BCD_WIDTH_DEF  = 8;
    localparam int unsigned BCD_DIGITS_DEF = 3;

    typedef enum logic [1:0] {
        BCD_IDLE  = 2'd0,
        BCD_SHIFT = 2'd1,
        BCD_DONE  = 2'd2
    } bcd_state_e;

    localparam logic CLIENT_TIMER = 1'b0;
    localparam logic CLIENT_SCORE = 1'b1;

    localparam logic [3:0]  ADD3_THRESH   = 4'd5;
    localparam logic [11:0] BCD_CLAMP_VAL = 12'h099;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble step: add 3 to every BCD nibble >= 5, then shift the
// whole register left by one bit.
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = BCD_WIDTH_DEF,
    parameter int unsigned DIGITS = BCD_DIGITS_DEF
) (
    input  logic [DIGITS*4+WIDTH-1:0] i_sr,
    output logic [DIGITS*4+WIDTH-1:0] o_sr
);

    localparam int unsigned SR_W = DIGITS * 4 + WIDTH;

    logic [SR_W-1:0] w_adj;

    always_comb begin
        w_adj = i_sr;
        // A nibble >= 5 tops out at 12 after the add, so no carry leaves it.
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (i_sr[WIDTH+4*d +: 4] >= ADD3_THRESH) begin
                w_adj[WIDTH+4*d +: 4] = i_sr[WIDTH+4*d +: 4] + 4'd3;
            end
        end
        o_sr = {w_adj[SR_W-2:0], 1'b0};
    end

endmodule

// File: rtl/bcd_convert_scheduler.sv
// Shared binary-to-BCD engine serving timer and score clients with round-robin
// arbitration. Define BCD_CLAMP_EN to saturate stored results above 99 to 12'h099.
module bcd_convert_scheduler
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = BCD_WIDTH_DEF,
    parameter int unsigned DIGITS = BCD_DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  timer_req,
    input  logic [WIDTH-1:0]      timer_bin,
    output logic                  timer_ack,
    output logic [4*DIGITS-1:0]   timer_bcd,
    input  logic                  score_req,
    input  logic [WIDTH-1:0]      score_bin,
    output logic                  score_ack,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic                  busy
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SR_W  = BCD_W + WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE  = BCD_IDLE;
    localparam logic [1:0] SHIFT = BCD_SHIFT;
    localparam logic [1:0] DONE  = BCD_DONE;

    logic [1:0]       r_state;
    logic             r_grant;
    logic             r_last_grant;
    logic [CNT_W-1:0] r_cnt;
    logic [SR_W-1:0]  r_sr;
    logic [BCD_W-1:0] r_timer_bcd;
    logic [BCD_W-1:0] r_score_bcd;
`ifdef BCD_CLAMP_EN
    logic [WIDTH-1:0] r_bin;
`endif

    logic             w_pick;
    logic [WIDTH-1:0] w_bin_sel;
    logic [SR_W-1:0]  w_sr_next;
    logic [BCD_W-1:0] w_bcd_store;
    logic             w_last_step;

    bcd_dabble_step #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_step (
        .i_sr (r_sr),
        .o_sr (w_sr_next)
    );

    always_comb begin
        w_pick = CLIENT_SCORE;
        if (timer_req && score_req) begin
            w_pick = (r_last_grant == CLIENT_TIMER) ? CLIENT_SCORE : CLIENT_TIMER;
        end else if (timer_req) begin
            w_pick = CLIENT_TIMER;
        end
        w_bin_sel = (w_pick == CLIENT_TIMER) ? timer_bin : score_bin;
    end

    assign w_last_step = (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_bcd_store = w_sr_next[SR_W-1 -: BCD_W];
`ifdef BCD_CLAMP_EN
        if (32'(r_bin) > 32'd99) begin
            w_bcd_store = BCD_W'(BCD_CLAMP_VAL);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= CLIENT_TIMER;
            r_last_grant <= CLIENT_SCORE;
            r_cnt        <= '0;
            r_sr         <= '0;
            r_timer_bcd  <= '0;
            r_score_bcd  <= '0;
`ifdef BCD_CLAMP_EN
            r_bin        <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (timer_req || score_req) begin
                        r_grant      <= w_pick;
                        r_last_grant <= w_pick;
                        r_sr         <= {{BCD_W{1'b0}}, w_bin_sel};
                        r_cnt        <= '0;
                        r_state      <= SHIFT;
`ifdef BCD_CLAMP_EN
                        r_bin        <= w_bin_sel;
`endif
                    end
                end
                SHIFT: begin
                    r_sr  <= w_sr_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last_step) begin
                        if (r_grant == CLIENT_TIMER) begin
                            r_timer_bcd <= w_bcd_store;
                        end else begin
                            r_score_bcd <= w_bcd_store;
                        end
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Acks are decoded from state and the registered grant only.
    assign timer_ack = (r_state == DONE) && (r_grant == CLIENT_TIMER);
    assign score_ack = (r_state == DONE) && (r_grant == CLIENT_SCORE);
    assign busy      = (r_state != IDLE);
    assign timer_bcd = r_timer_bcd;
    assign score_bcd = r_score_bcd;

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// Directed self-checking bench for bcd_convert_scheduler (honours BCD_CLAMP_EN).
module tb_bcd_convert_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        timer_req;
    logic [7:0]  timer_bin;
    logic        timer_ack;
    logic [11:0] timer_bcd;
    logic        score_req;
    logic [7:0]  score_bin;
    logic        score_ack;
    logic [11:0] score_bcd;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    bcd_convert_scheduler #(
        .WIDTH  (8),
        .DIGITS (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .timer_req (timer_req),
        .timer_bin (timer_bin),
        .timer_ack (timer_ack),
        .timer_bcd (timer_bcd),
        .score_req (score_req),
        .score_bin (score_bin),
        .score_ack (score_ack),
        .score_bcd (score_bcd),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Ticks until the selected ack is seen (sampling edge counts as tick 1); -1 on timeout.
    task automatic wait_ack(input bit is_timer, output int n);
        bit seen;
        n = -1;
        seen = 1'b0;
        for (int i = 1; i <= 30 && !seen; i++) begin
            tick();
            if ((is_timer && timer_ack) || (!is_timer && score_ack)) begin
                n = i;
                seen = 1'b1;
            end
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        timer_req = 1'b0;
        score_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int    n;
    int    acks;
    bit    who;
    logic  exp_who;
    logic [11:0] exp255;

    initial begin
        timer_bin = '0;
        score_bin = '0;
        do_reset();

        check("rst_timer_bcd", 32'(timer_bcd), 32'h0);
        check("rst_score_bcd", 32'(score_bcd), 32'h0);
        check("rst_acks", {30'b0, timer_ack, score_ack}, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // Single timer request of 59.
        timer_bin = 8'd59;
        timer_req = 1'b1;
        wait_ack(1'b1, n);
        timer_req = 1'b0;
        check("t59_latency", n, 9);
        check("t59_bcd", 32'(timer_bcd), 32'h059);
        check("t59_score_untouched", 32'(score_bcd), 32'h0);
        check("t59_busy_in_done", 32'(busy), 32'h1);
        tick();
        check("t59_ack_one_cycle", 32'(timer_ack), 32'h0);
        check("t59_idle_busy", 32'(busy), 32'h0);

        // Tie after reset: timer first, score ten cycles later.
        do_reset();
        timer_bin = 8'd30;
        score_bin = 8'd7;
        timer_req = 1'b1;
        score_req = 1'b1;
        wait_ack(1'b1, n);
        timer_req = 1'b0;
        check("tie_timer_latency", n, 9);
        check("tie_timer_bcd", 32'(timer_bcd), 32'h030);
        check("tie_score_not_acked", 32'(score_ack), 32'h0);
        wait_ack(1'b0, n);
        score_req = 1'b0;
        check("tie_score_gap", n, 10);
        check("tie_score_bcd", 32'(score_bcd), 32'h007);
        check("tie_timer_held", 32'(timer_bcd), 32'h030);
        tick();

        // Continuous contention: grants alternate T,S,T,S,T,S.
        do_reset();
        timer_bin = 8'd123;
        score_bin = 8'd200;
        timer_req = 1'b1;
        score_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n = -1;
            who = 1'b0;
            for (int i = 1; i <= 15 && n < 0; i++) begin
                tick();
                if (timer_ack || score_ack) begin
                    n = i;
                    who = score_ack;
                    check("rr_single_ack", 32'(timer_ack & score_ack), 32'h0);
                end
            end
            exp_who = k[0];
            check("rr_grant_order", 32'(who), 32'(exp_who));
            check("rr_gap", n, (k == 0) ? 9 : 10);
        end
        timer_req = 1'b0;
        score_req = 1'b0;
        check("rr_timer_bcd", 32'(timer_bcd), 32'h123);
        check("rr_score_bcd", 32'(score_bcd), 32'h200);
        tick();
        tick();

        // Boundary values 255 and 0 on the score client.
`ifdef BCD_CLAMP_EN
        exp255 = 12'h099;
`else
        exp255 = 12'h255;
`endif
        score_bin = 8'd255;
        score_req = 1'b1;
        wait_ack(1'b0, n);
        score_req = 1'b0;
        check("s255_latency", n, 9);
        check("s255_bcd", 32'(score_bcd), 32'(exp255));
        tick();
        score_bin = 8'd0;
        score_req = 1'b1;
        wait_ack(1'b0, n);
        score_req = 1'b0;
        check("s0_bcd", 32'(score_bcd), 32'h000);
        tick();

        // Reset four cycles into SHIFT abandons the conversion.
        timer_bin = 8'd200;
        timer_req = 1'b1;
        tick();
        timer_req = 1'b0;
        repeat (4) tick();
        check("rst_mid_busy_before", 32'(busy), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_timer_bcd", 32'(timer_bcd), 32'h0);
        check("rst_mid_score_bcd", 32'(score_bcd), 32'h0);
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            if (timer_ack || score_ack) acks++;
            tick();
        end
        check("rst_mid_no_ack", acks, 0);
        timer_bin = 8'd42;
        timer_req = 1'b1;
        wait_ack(1'b1, n);
        timer_req = 1'b0;
        check("post_rst_latency", n, 9);
        check("post_rst_bcd", 32'(timer_bcd), 32'h042);
        tick();

        // Input changed during SHIFT is ignored.
        timer_bin = 8'd17;
        timer_req = 1'b1;
        tick();
        tick();
        tick();
        timer_bin = 8'd88;
        n = -1;
        for (int i = 4; i <= 30 && n < 0; i++) begin
            tick();
            if (timer_ack) n = i;
        end
        timer_req = 1'b0;
        check("latch_latency", n, 9);
        check("latch_bcd", 32'(timer_bcd), 32'h017);
        check("latch_score_held", 32'(score_bcd), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
